// File: rtl/mem_bus_pkg.sv
// Shared definitions for the external memory bus arbiter.
//   state_t : sequencer states (IDLE, ACCESS, ACK)
//   ADDR_W  : default external bus address width
//   DATA_W  : default external bus data width
//   WAIT_W  : width of the per-access wait-state counter (0..15 waits)
package mem_bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with its priority pointer.
//   clk, reset : clock and asynchronous active-high reset
//   req0, req1 : request lines of master 0 and master 1
//   take       : high in the cycle a grant is actually accepted
//   gnt        : granted master index (combinational)
//   rr_ptr     : master that wins the next tie
module rr_arbiter2
    import mem_bus_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt,
    output logic rr_ptr
);

    // A lone requester always wins; rr_ptr only breaks ties.
    always_comb begin
        gnt = rr_ptr;
        if (req0 && !req1) begin
            gnt = 1'b0;
        end else if (req1 && !req0) begin
            gnt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (take) begin
            rr_ptr <= ~gnt;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and sequencer for the shared external memory bus.
// One access at a time: IDLE (grant) -> ACCESS (WAIT_STATES+1 cycles) -> ACK.
//   clk, reset              : clock and asynchronous active-high reset
//   mN_req/we/addr/wdata    : master N request, direction, address, write data
//   mN_rdata, mN_ack        : master N read data (held) and one-cycle completion
//   bus_addr, bus_data      : external address and tri-state data bus
//   read, write             : external bus strobes
//   busy                    : sequencer is not IDLE
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = mem_bus_pkg::ADDR_W,
    parameter int DATA_W      = mem_bus_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] bus_addr,
    inout  wire  [DATA_W-1:0] bus_data,
    output logic              read,
    output logic              write,
    output logic              busy
);

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_q;
    logic                owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   m0_rdata_q;
    logic [DATA_W-1:0]   m1_rdata_q;
    logic                gnt;
    logic                rr_ptr;
    logic                any_req;
    logic                take;
    logic                last;
    logic                drive;

    assign any_req = m0_req | m1_req;
    assign take    = (state_q == IDLE) && any_req;
    assign last    = (wait_q == WAIT_W'(WAIT_STATES));

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req0   (m0_req),
        .req1   (m1_req),
        .take   (take),
        .gnt    (gnt),
        .rr_ptr (rr_ptr)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (last)    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Wait counter, bus address and read-data capture carry visible reset values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q     <= '0;
            addr_q     <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (state_q == ACCESS && !last) begin
                wait_q <= wait_q + 1'b1;
            end else begin
                wait_q <= '0;
            end
            if (take) begin
                addr_q <= gnt ? m1_addr : m0_addr;
            end
            // Asynchronous memory: data is taken on the edge closing the access
            if (state_q == ACCESS && last && !we_q) begin
                if (owner_q) begin
                    m1_rdata_q <= bus_data;
                end else begin
                    m0_rdata_q <= bus_data;
                end
            end
        end
    end

    // Transaction attributes are only consumed outside IDLE, so they need no reset
    always_ff @(posedge clk) begin
        if (take) begin
            owner_q <= gnt;
            we_q    <= gnt ? m1_we    : m0_we;
            wdata_q <= gnt ? m1_wdata : m0_wdata;
        end
    end

    // Outputs decode from state only, so reset clears them immediately
    always_comb begin
        read   = 1'b0;
        write  = 1'b0;
        drive  = 1'b0;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        busy   = (state_q != IDLE);
        case (state_q)
            ACCESS: begin
                read  = !we_q;
                drive = we_q;
                // One strobe in the final cycle gives exactly one commit edge
                write = we_q && last;
            end
            ACK: begin
                m0_ack = !owner_q;
                m1_ack = owner_q;
            end
            default: ;
        endcase
    end

    assign bus_data = drive ? wdata_q : {DATA_W{1'bz}};
    assign bus_addr = addr_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared external memory bus: 16-bit tri-state bus_data, 20-bit bus_addr, and read/write strobes.
- Master 0 is the pipeline MEM-stage port; master 1 is a secondary requester (DMA or debug loader).
- Arbitrates with round-robin priority and drives one access at a time.
- Honours the memory's timing: asynchronous read, write committed at a clock edge.
- Returns read data and a one-cycle ack to the granted master.

Parameters:
- WAIT_STATES, 0, extra cycles each access holds the bus (0..15) for slow or address-decoded devices.
- ADDR_W, 20, bus address width.
- DATA_W, 16, bus data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 request; held high until m0_ack.
- m0_we  in  1  master 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_rdata  out  DATA_W  master 0 read data; valid in the m0_ack cycle and held afterwards.
- m0_ack  out  1  master 0 completion pulse, one cycle.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same as the m0 ports, for master 1.
- bus_addr  out  ADDR_W  external bus address.
- bus_data  inout  DATA_W  external data bus; driven only during write access, otherwise high-Z.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset is asynchronous and active-high and takes effect immediately, including mid-access. While reset is high:
  - state = IDLE, rr_ptr = 0, wait counter = 0.
  - bus_addr = 0; read = write = 0; bus_data = Z.
  - m0_ack = m1_ack = 0; m0_rdata = m1_rdata = 0; busy = 0.
  - Any in-flight access is abandoned: no ack, and no write edge occurs.
- State machine:
  - IDLE -> ACCESS when either req is high.
  - ACCESS -> ACK after WAIT_STATES+1 cycles.
  - ACK -> IDLE unconditionally.
- Grant, decided in IDLE:
  - Only one req high: that master is granted.
  - Both high: the master indicated by rr_ptr is granted.
  - On grant, rr_ptr <= the other master.
  - The granted master's we, addr and wdata are latched into internal registers. The master's inputs are not used again until the next grant.
- ACCESS:
  - bus_addr = latched address for all cycles.
  - Read access: read = 1 for all cycles. bus_data is sampled on the clock edge that ends the last ACCESS cycle and written into the granted master's rdata register.
  - Write access: bus_data = latched wdata for all cycles. write = 1 only in the last ACCESS cycle, so exactly one write edge reaches memory. Write access leaves rdata unchanged.
  - read and write are never high together.
- ACK:
  - The granted master's ack = 1 for exactly one cycle.
  - read = write = 0; bus_data = Z; bus_addr holds its value.
  - Requests are not sampled in ACK. The next grant is decided in the following IDLE cycle, which gives one bus-turnaround cycle between accesses.
- Latency: req sampled high in IDLE at edge N -> ACCESS from N+1 to N+1+WAIT_STATES -> ack in cycle N+2+WAIT_STATES.
  - Minimum 3 cycles per transaction.
  - Back-to-back throughput: one access per WAIT_STATES+3 cycles.
- Boundaries:
  - req dropped mid-transaction: the access still completes and ack is still issued.
  - req still high after ack: treated as a new request in IDLE.
  - Both masters requesting continuously: grants alternate 0,1,0,1; neither master starves.
  - Address decoding is the memory devices' job. An address no device claims returns the floating bus value, and the arbiter issues ack regardless.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2.
  - ADDR_W and DATA_W constants.
  - WAIT_W = 4 (wait-counter width).
- One sub-module: rr_arbiter2, a combinational two-way round-robin grant plus the rr_ptr flop.
- Everything else stays in the top-level FSM.

Test Plan:
- Read, W=0: memory[0x00010] = 0xBEEF; m0 read at 0x00010 -> read high for 1 cycle, m0_ack 2 cycles after req sampled, m0_rdata = 0xBEEF.
- Write then read, W=2: m1 writes 0x1234 to 0x00020 -> write high only in the 3rd ACCESS cycle; memory written once. m1 then reads 0x00020 -> m1_rdata = 0x1234, ack 4 cycles after req.
- Contention: m0 and m1 request continuously with reset rr_ptr = 0 -> grant order m0, m1, m0, m1. Each ack goes only to its own master; bus_data = Z in all ACK and IDLE cycles.
- Request withdrawn: m0_req pulses for 1 cycle -> access still completes and m0_ack is issued once.
- Reset mid-write, W=3: assert reset in the 2nd ACCESS cycle -> write never asserts, bus_data goes Z at once, memory is unchanged, no ack, and all outputs return to their reset values.
- Turnaround: checker asserts read and write are never both high, and bus_data is driven only when write access is in ACCESS.
